// File: rtl/fifo_rr_scheduler_if.sv
// fifo_rr_scheduler_if: upstream FIFO pop, downstream write and watermark signals of the round-robin scheduler
interface fifo_rr_scheduler_if #(
  parameter int DATA_BITS = 10,
  parameter int ADDR_BITS = 3
);
  logic [3:0]             fifo_empty;
  logic [4*DATA_BITS-1:0] fifo_data;
  logic [ADDR_BITS:0]     down_count;
  logic [ADDR_BITS-1:0]   high_limit;
  logic [ADDR_BITS-1:0]   low_limit;
  logic [3:0]             fifo_read;
  logic [DATA_BITS-1:0]   data_out;
  logic                   fifo_write;
  logic [1:0]             grant;
  logic                   paused;
  logic                   cfg_error;
  modport master (
    output fifo_empty, fifo_data, down_count, high_limit, low_limit,
    input  fifo_read, data_out, fifo_write, grant, paused, cfg_error
  );
  modport slave (
    input  fifo_empty, fifo_data, down_count, high_limit, low_limit,
    output fifo_read, data_out, fifo_write, grant, paused, cfg_error
  );
endinterface

// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: pops four upstream FIFOs round-robin into one downstream FIFO with watermark hysteresis
module fifo_rr_scheduler #(
  parameter int DATA_BITS = 10,
  parameter int ADDR_BITS = 3
) (
  input logic clk,
  input logic reset,
  fifo_rr_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, PAUSE} state_t;
  state_t     state;
  logic [1:0] last;
  logic [1:0] win;
  logic [1:0] cap_idx;
  logic       cap_valid;
  logic [3:0] elig;
  logic       cfg_bad;
  logic       over_high;
  logic       under_low;
  logic       to_pause;
  logic       to_grant;
  assign cfg_bad   = {1'b0, bus.low_limit} >= {1'b0, bus.high_limit};
  assign over_high = bus.down_count >= {1'b0, bus.high_limit};
  assign under_low = bus.down_count <= {1'b0, bus.low_limit};
  // a FIFO popped this cycle still shows its pre-pop empty flag, so skip it
  assign elig      = ~bus.fifo_empty & ~bus.fifo_read;
  assign to_pause  = !cfg_bad && (state == PAUSE ? !under_low : over_high);
  assign to_grant  = !cfg_bad && !to_pause && |elig;
  always_comb begin
    win = last;
    for (int k = 4; k >= 1; k--)
      if (elig[2'(32'(last) + k)]) win = 2'(32'(last) + k);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last          <= 2'd3;
      bus.fifo_read <= '0;
      bus.grant     <= '0;
      bus.paused    <= 1'b0;
      bus.cfg_error <= 1'b0;
      cap_valid     <= 1'b0;
      cap_idx       <= '0;
      bus.fifo_write <= 1'b0;
      bus.data_out  <= '0;
    end else begin
      state         <= to_pause ? PAUSE : to_grant ? GRANT : IDLE;
      bus.fifo_read <= to_grant ? 4'b0001 << win : 4'b0000;
      if (to_grant) begin
        last      <= win;
        bus.grant <= win;
      end
      bus.paused     <= to_pause;
      bus.cfg_error  <= cfg_bad;
      cap_valid      <= |bus.fifo_read;
      cap_idx        <= bus.grant;
      bus.fifo_write <= cap_valid;
      if (cap_valid) bus.data_out <= bus.fifo_data[32'(cap_idx)*DATA_BITS +: DATA_BITS];
    end
  end
  a_onehot_read: assert property (@(posedge clk) disable iff (reset) $onehot0(bus.fifo_read));
  a_no_pop_paused: assert property (@(posedge clk) disable iff (reset) !(bus.paused && |bus.fifo_read));
  a_grant_idx: assert property (@(posedge clk) disable iff (reset) |bus.fifo_read |-> bus.fifo_read[bus.grant]);
endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb_fifo_rr_scheduler: directed and randomized checks of fifo_rr_scheduler against a lane-queue reference model
module tb_fifo_rr_scheduler;
  localparam int DB = 10;
  localparam int AB = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  fifo_rr_scheduler_if #(.DATA_BITS(DB), .ADDR_BITS(AB)) io();
  fifo_rr_scheduler #(.DATA_BITS(DB), .ADDR_BITS(AB)) dut (.clk(clk), .reset(reset), .bus(io.slave));
  int n_checks = 0;
  int n_fail = 0;
  logic [DB-1:0] mem [4][512];
  int head [4];
  int tail [4];
  logic [DB-1:0] lane_d [4];
  bit m_paused;
  int m_last;
  logic [3:0] m_rd;
  logic [1:0] e_gr;
  logic e_pa, e_cfg, e_fw;
  logic [DB-1:0] e_do;
  bit pv [2];
  logic [DB-1:0] pd [2];
  task automatic sync_lanes();
    for (int i = 0; i < 4; i++) io.fifo_empty[i] = (head[i] == tail[i]);
    io.fifo_data = {lane_d[3], lane_d[2], lane_d[1], lane_d[0]};
  endtask
  task automatic push(input int i, input logic [DB-1:0] w);
    mem[i][tail[i]] = w;
    tail[i]++;
    sync_lanes();
  endtask
  task automatic model_reset();
    m_paused = 0; m_last = 3; m_rd = '0; e_gr = '0;
    e_pa = 0; e_cfg = 0; e_fw = 0; e_do = '0;
    pv[0] = 0; pv[1] = 0; pd[0] = '0; pd[1] = '0;
    for (int i = 0; i < 4; i++) begin head[i] = 0; tail[i] = 0; lane_d[i] = '0; end
    sync_lanes();
  endtask
  // expected outputs after the coming rising edge, from the inputs presented now
  task automatic predict();
    int dc, hi, lo, win;
    bit granted;
    logic [3:0] prev;
    dc = int'(io.down_count); hi = int'(io.high_limit); lo = int'(io.low_limit);
    prev = m_rd; granted = 0; win = 0;
    e_fw = pv[1];
    if (pv[1]) e_do = pd[1];
    pv[1] = pv[0]; pd[1] = pd[0];
    e_cfg = lo >= hi;
    if (e_cfg) m_paused = 0;
    else if (m_paused) m_paused = !(dc <= lo);
    else m_paused = dc >= hi;
    m_rd = '0;
    if (!e_cfg && !m_paused)
      for (int k = 1; k <= 4; k++) begin
        automatic int i = (m_last + k) % 4;
        if (!granted && head[i] != tail[i] && !prev[i]) begin granted = 1; win = i; end
      end
    if (granted) begin m_rd = 4'b0001 << win; m_last = win; e_gr = 2'(win); end
    pv[0] = granted;
    pd[0] = granted ? mem[win][head[win]] : '0;
    e_pa = m_paused;
  endtask
  task automatic tick();
    predict();
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      if (io.fifo_read[i] && head[i] != tail[i]) begin lane_d[i] = mem[i][head[i]]; head[i]++; end
    sync_lanes();
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    io.down_count = '0; io.high_limit = 3'd5; io.low_limit = 3'd2;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask
  task automatic test_reset();
    logic [18:0] obs, exp;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 3; j++) push(i, 10'(i * 16 + j + 7));
    for (int t = 0; t < 4; t++) begin
      tick();
      obs = {io.fifo_read, io.grant, io.paused, io.cfg_error, io.fifo_write, io.data_out};
      exp = {m_rd, e_gr, e_pa, e_cfg, e_fw, e_do};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL reset_prestream t=%0d: got %h want %h", t, obs, exp); end
    end
    #2 reset = 1'b1;
    #1;
    obs = {io.fifo_read, io.grant, io.paused, io.cfg_error, io.fifo_write, io.data_out};
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_async_zero: got %h want 0", obs); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int t = 0; t < 4; t++) begin
      tick();
      n_checks++;
      if (io.fifo_read !== 4'b0000 || io.fifo_write !== 1'b0) begin
        n_fail++; $display("FAIL reset_idle t=%0d: got read %b write %b want 0000 0", t, io.fifo_read, io.fifo_write);
      end
    end
  endtask
  task automatic test_single_lane();
    logic [3:0] lit_rd [6] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    logic lit_fw [6] = '{0, 0, 1, 0, 1, 0};
    logic [DB-1:0] lit_do [6] = '{10'h000, 10'h000, 10'h155, 10'h155, 10'h2AA, 10'h2AA};
    do_reset();
    push(0, 10'h155);
    push(0, 10'h2AA);
    for (int t = 0; t < 6; t++) begin
      tick();
      n_checks++;
      if ({io.fifo_read, io.fifo_write, io.data_out} !== {lit_rd[t], lit_fw[t], lit_do[t]}) begin
        n_fail++;
        $display("FAIL single_lane t=%0d: got rd %b wr %b data %h want rd %b wr %b data %h",
                 t, io.fifo_read, io.fifo_write, io.data_out, lit_rd[t], lit_fw[t], lit_do[t]);
      end
    end
  endtask
  task automatic test_round_robin();
    logic [3:0] lit_rd [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    do_reset();
    for (int i = 0; i < 4; i++) begin push(i, 10'(i + 1)); push(i, 10'(i + 1)); end
    for (int t = 0; t < 6; t++) begin
      tick();
      n_checks++;
      if (io.fifo_read !== lit_rd[t]) begin
        n_fail++; $display("FAIL round_robin_read t=%0d: got %b want %b", t, io.fifo_read, lit_rd[t]);
      end
      if (t >= 2) begin
        n_checks++;
        if (io.fifo_write !== 1'b1 || io.data_out !== 10'(t - 1)) begin
          n_fail++; $display("FAIL round_robin_data t=%0d: got wr %b data %h want 1 %h", t, io.fifo_write, io.data_out, 10'(t - 1));
        end
      end
    end
  endtask
  task automatic test_hysteresis();
    int dc_seq [9] = '{0, 0, 4, 5, 4, 3, 2, 0, 0};
    logic lit_pa [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    int writes_in_pause = 0;
    logic [18:0] obs, exp;
    do_reset();
    for (int i = 0; i < 4; i++) for (int j = 0; j < 6; j++) push(i, 10'($urandom_range(0, 1023)));
    for (int t = 0; t < 9; t++) begin
      io.down_count = 4'(dc_seq[t]);
      tick();
      obs = {io.fifo_read, io.grant, io.paused, io.cfg_error, io.fifo_write, io.data_out};
      exp = {m_rd, e_gr, e_pa, e_cfg, e_fw, e_do};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL hysteresis_model t=%0d: got %h want %h", t, obs, exp); end
      n_checks++;
      if (io.paused !== lit_pa[t] || (lit_pa[t] && io.fifo_read !== 4'b0000)) begin
        n_fail++; $display("FAIL hysteresis_pause t=%0d: got paused %b rd %b want paused %b", t, io.paused, io.fifo_read, lit_pa[t]);
      end
      if (lit_pa[t] && io.fifo_write === 1'b1) writes_in_pause++;
      if (t == 6) begin
        n_checks++;
        if (io.fifo_read === 4'b0000) begin n_fail++; $display("FAIL hysteresis_resume: got rd 0000 want nonzero"); end
      end
    end
    n_checks++;
    if (writes_in_pause > 2) begin n_fail++; $display("FAIL hysteresis_overrun: got %0d writes want <= 2", writes_in_pause); end
  endtask
  task automatic test_cfg_error();
    logic [18:0] obs, exp;
    do_reset();
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) push(i, 10'(i * 64 + j));
    tick();
    tick();
    io.high_limit = 3'd2; io.low_limit = 3'd6;
    for (int t = 0; t < 3; t++) begin
      tick();
      obs = {io.fifo_read, io.grant, io.paused, io.cfg_error, io.fifo_write, io.data_out};
      exp = {m_rd, e_gr, e_pa, e_cfg, e_fw, e_do};
      n_checks++;
      if (obs !== exp || io.cfg_error !== 1'b1 || io.fifo_read !== 4'b0000) begin
        n_fail++; $display("FAIL cfg_error_hold t=%0d: got %h want %h", t, obs, exp);
      end
    end
    io.low_limit = 3'd1;
    tick();
    n_checks++;
    if (io.cfg_error !== 1'b0 || io.fifo_read !== 4'b0100) begin
      n_fail++; $display("FAIL cfg_error_resume: got cfg %b rd %b want 0 0100", io.cfg_error, io.fifo_read);
    end
  endtask
  task automatic test_reset_stream();
    do_reset();
    push(2, 10'h3C3);
    tick();
    n_checks++;
    if (io.fifo_read !== 4'b0100) begin n_fail++; $display("FAIL reset_stream_pop: got %b want 0100", io.fifo_read); end
    tick();
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int t = 0; t < 3; t++) begin
      tick();
      n_checks++;
      if (io.fifo_write !== 1'b0) begin n_fail++; $display("FAIL reset_stream_nowrite t=%0d: got %b want 0", t, io.fifo_write); end
    end
    push(2, 10'h011);
    push(0, 10'h022);
    tick();
    n_checks++;
    if (io.fifo_read !== 4'b0001) begin n_fail++; $display("FAIL reset_stream_first: got %b want 0001", io.fifo_read); end
  endtask
  task automatic test_random();
    logic [18:0] obs, exp;
    do_reset();
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 3) == 0 && tail[i] < 500) push(i, 10'($urandom_range(0, 1023)));
      io.down_count = 4'($urandom_range(0, 8));
      if (t % 60 == 59) begin
        io.high_limit = 3'($urandom_range(0, 7));
        io.low_limit = 3'($urandom_range(0, 7));
      end
      tick();
      obs = {io.fifo_read, io.grant, io.paused, io.cfg_error, io.fifo_write, io.data_out};
      exp = {m_rd, e_gr, e_pa, e_cfg, e_fw, e_do};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL random t=%0d: got %h want %h", t, obs, exp); end
    end
  endtask
  initial begin
    io.down_count = '0; io.high_limit = 3'd5; io.low_limit = 3'd2;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_single_lane();
    test_round_robin();
    test_hysteresis();
    test_cfg_error();
    test_reset_stream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_rr_scheduler.md
# fifo_rr_scheduler

Round-robin read scheduler for four upstream FIFOs that merge into one downstream FIFO. The block pops at most one upstream FIFO per cycle and forwards the popped word to the downstream write port. It applies high/low watermark hysteresis on the downstream fill level, so the downstream FIFO never overruns. It sits between the per-lane FIFOs and the shared downstream FIFO, and owns all of their `fifo_read` and `fifo_write` strobes.

## Interface
- `DATA_BITS`, 10, width of one data word
- `ADDR_BITS`, 3, address width of the downstream FIFO; its depth is 2^ADDR_BITS
- `clk`, in, 1, single clock; all state updates on the rising edge
- `reset`, in, 1, asynchronous, active-high reset
- `fifo_empty`, in, 4, empty flag of upstream FIFO i on bit i
- `fifo_data`, in, 4*DATA_BITS, data of FIFO i on `[i*DATA_BITS +: DATA_BITS]`; valid the cycle after that FIFO samples its read strobe
- `down_count`, in, ADDR_BITS+1, downstream FIFO occupancy, range 0..2^ADDR_BITS
- `high_limit`, in, ADDR_BITS, pause threshold
- `low_limit`, in, ADDR_BITS, resume threshold
- `fifo_read`, out, 4, one-hot pop strobe to the upstream FIFOs
- `data_out`, out, DATA_BITS, word sent to the downstream FIFO
- `fifo_write`, out, 1, downstream write strobe; qualifies `data_out`
- `grant`, out, 2, index of the FIFO popped in the current cycle
- `paused`, out, 1, high while in the PAUSE state
- `cfg_error`, out, 1, high while `low_limit >= high_limit`

## Operation
- **State machine:** IDLE, GRANT, PAUSE. All outputs are registered.
- **IDLE:** `fifo_read = 0`.
  - Go to PAUSE if `down_count >= high_limit`.
  - Otherwise go to GRANT if some FIFO is eligible.
- **GRANT:** assert `fifo_read[i]` for the winner; `grant = i`.
  - Go to PAUSE if `down_count >= high_limit`.
  - Go to IDLE if no FIFO is eligible.
- **PAUSE:** `fifo_read = 0`, `paused = 1`.
  - Leave PAUSE only when `down_count <= low_limit`.
  - Go to GRANT if some FIFO is eligible, else IDLE.
- **Eligibility:** FIFO i is eligible when `fifo_empty[i] = 0` and i was not popped in the previous cycle.
  - This prevents a double pop on a stale empty flag.
  - A lone non-empty FIFO is therefore popped at most every other cycle.
- **Round robin:** pointer `last` holds the most recent grant. The winner is the first eligible index searching `last+1, last+2, …` modulo 4. `last` updates only when a grant is issued.
- **Config error:** while `cfg_error = 1` the block is forced to IDLE and issues no grants. In-flight words still complete.
- **Capture pipeline:** the grant index is delayed one cycle. The block then muxes `fifo_data` by that index into `data_out` and pulses `fifo_write`.
- **Comparisons:** unsigned. `high_limit` and `low_limit` are zero-extended to ADDR_BITS+1 bits.

## Timing
- **Reset values:** while `reset` is high, all of the following are 0: `fifo_read`, `data_out`, `fifo_write`, `grant`, `paused`, `cfg_error`. State is IDLE and `last = 3`, so the first grant goes to FIFO 0.
- **Reset mid-operation:** any in-flight capture is discarded, and no `fifo_write` appears after reset release for pops issued before reset.
- **Pop-to-write latency:**
  - Edge k: `fifo_read[i]` rises.
  - Edge k+1: FIFO i samples the read and presents data.
  - Edge k+2: `data_out` and `fifo_write = 1`.
- **Pause reaction:** one cycle. `down_count >= high_limit` sampled at edge k means no `fifo_read` after edge k.
- **Overrun margin:** up to 2 in-flight words still write after entering PAUSE. `high_limit` must be at most depth − 3 for overrun-free use.
- **Simultaneous conditions:**
  - Pause and eligible FIFO in the same cycle: pause wins.
  - `down_count >= high_limit` and `<= low_limit` both true can only happen with `cfg_error` set, and `cfg_error` wins.
- **Throughput:** one word per cycle when at least two FIFOs are non-empty and the block is not paused.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle → every output is 0 immediately. After release with all FIFOs empty, the block stays in IDLE with `fifo_read = 0000`.
- **Single lane:** only FIFO 0 non-empty, holding 0x155 and 0x2AA → `fifo_read` goes 0001, 0000, 0001. `fifo_write` pulses 2 cycles after each pop, with `data_out` 0x155 then 0x2AA.
- **Full round robin:** all four FIFOs non-empty, FIFO i holding value i+1 → `fifo_read` goes 0001, 0010, 0100, 1000, 0001 on consecutive cycles. `data_out` goes 1, 2, 3, 4, each 2 cycles after its pop.
- **Hysteresis:** `high_limit = 5`, `low_limit = 2`, `down_count` ramped 4, 5, 4, 3, 2 → `paused` rises the cycle after 5 and stays high through 4 and 3. Reads resume the cycle after 2. At most 2 writes occur after the pause.
- **Config error:** `high_limit = 2`, `low_limit = 6` with FIFOs non-empty → `cfg_error = 1` and no `fifo_read`. Setting `low_limit = 1` clears the error, and grants resume starting from `last + 1`.
- **Reset during stream:** assert reset one cycle after a pop → no `fifo_write` for that pop. The first grant after release goes to FIFO 0.
